// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
// mem_src_t names who owns an in-flight read.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_FETCH,
        SRC_DATA
    } mem_src_t;

    localparam int STREAK_W = 4;

endpackage

// File: rtl/mem_arb_tag_pipe.sv
// Reset-cleared delay line of read-source tags.
// One stage per cycle of memory read latency.
module mem_arb_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic     clk,
    input  logic     rst,
    input  mem_src_t src_in,
    output mem_src_t src_out
);

    mem_src_t stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage[i] <= SRC_NONE;
            end
        end else begin
            stage[0] <= src_in;
            for (int i = 1; i < DEPTH; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign src_out = stage[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between instruction fetch and
// the load/store path; steers read responses back to their requester.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W          = 32,
    parameter int MEM_LATENCY     = 1,
    parameter int MAX_DATA_STREAK = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [29:0]       if_addr,
    output logic              if_ready,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [31:0]       mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wdata_oe,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              hold,
    output logic              block_inst
);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_DATA_STREAK);

    logic [STREAK_W-1:0] streak;
    logic                streak_hit;
    logic                grant_data;
    logic                grant_fetch;
    mem_src_t            issue_src;
    mem_src_t            resp_src;

    // Handshake: a requester holds req (and its address/data) until it sees
    // ready=1 in the same cycle; that cycle is the transfer. rvalid is a
    // one-cycle pulse with no back-pressure, in grant order.
    assign streak_hit  = (streak == STREAK_MAX);
    assign grant_data  = !rst && d_req && !(if_req && streak_hit);
    assign grant_fetch = !rst && if_req && !grant_data;

    assign if_ready = grant_fetch;
    assign d_ready  = grant_data;
    assign hold     = !rst && if_req && !grant_fetch;

    // Counts data grants that made a waiting fetch lose arbitration.
    always_ff @(posedge clk) begin
        if (rst) begin
            streak <= '0;
        end else if (grant_data && if_req) begin
            streak <= streak_hit ? streak : streak + 1'b1;
        end else begin
            streak <= '0;
        end
    end

    always_comb begin
        mem_addr     = {if_addr, 2'b00};
        mem_we       = 1'b0;
        mem_wdata_oe = 1'b0;
        mem_wdata    = '0;
        issue_src    = SRC_NONE;
        if (rst) begin
            mem_addr = '0;
        end else if (grant_data) begin
            mem_addr     = d_addr;
            mem_we       = d_we;
            mem_wdata_oe = d_we;
            mem_wdata    = d_we ? d_wdata : '0;
            issue_src    = d_we ? SRC_NONE : SRC_DATA;
        end else if (grant_fetch) begin
            issue_src = SRC_FETCH;
        end
    end

    mem_arb_tag_pipe #(
        .DEPTH (MEM_LATENCY)
    ) u_tag_pipe (
        .clk     (clk),
        .rst     (rst),
        .src_in  (issue_src),
        .src_out (resp_src)
    );

    // Gated by rst so a tag still in flight when reset rises never shows up.
    assign if_rvalid  = !rst && (resp_src == SRC_FETCH);
    assign d_rvalid   = !rst && (resp_src == SRC_DATA);
    assign if_rdata   = if_rvalid ? mem_rdata : '0;
    assign d_rdata    = d_rvalid ? mem_rdata : '0;
    assign block_inst = !if_rvalid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table at latency 1,
// plus starvation and latency-3 ordering sequences.
module tb_mem_port_arbiter;

    localparam logic [31:0] IB = 32'hA000_0000;

    typedef struct {
        logic        rst;
        logic        if_req;
        logic [29:0] if_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
        logic        e_if_ready;
        logic        e_d_ready;
        logic        e_hold;
        logic [31:0] e_mem_addr;
        logic        e_mem_we;
        logic        e_oe;
        logic [31:0] e_mem_wdata;
        logic        e_if_rvalid;
        logic [31:0] e_if_rdata;
        logic        e_d_rvalid;
        logic [31:0] e_d_rdata;
        logic        e_block;
    } vec_t;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT, latency 1 ----------------
    logic        if_req, if_ready, if_rvalid, d_req, d_we, d_ready, d_rvalid;
    logic        mem_we, mem_wdata_oe, hold, block_inst;
    logic [29:0] if_addr;
    logic [31:0] d_addr, d_wdata, if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    mem_port_arbiter #(.DATA_W(32), .MEM_LATENCY(1), .MAX_DATA_STREAK(4)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_wdata_oe(mem_wdata_oe), .mem_rdata(mem_rdata),
        .hold(hold), .block_inst(block_inst)
    );

    // ---------------- DUT, latency 3 ----------------
    logic        t3_if_req, t3_if_ready, t3_if_rvalid, t3_d_req, t3_d_we, t3_d_ready, t3_d_rvalid;
    logic        t3_mem_we, t3_mem_wdata_oe, t3_hold, t3_block_inst;
    logic [29:0] t3_if_addr;
    logic [31:0] t3_d_addr, t3_d_wdata, t3_if_rdata, t3_d_rdata;
    logic [31:0] t3_mem_addr, t3_mem_wdata, t3_mem_rdata;

    mem_port_arbiter #(.DATA_W(32), .MEM_LATENCY(3), .MAX_DATA_STREAK(4)) u_dut3 (
        .clk(clk), .rst(rst),
        .if_req(t3_if_req), .if_addr(t3_if_addr), .if_ready(t3_if_ready),
        .if_rvalid(t3_if_rvalid), .if_rdata(t3_if_rdata),
        .d_req(t3_d_req), .d_we(t3_d_we), .d_addr(t3_d_addr), .d_wdata(t3_d_wdata),
        .d_ready(t3_d_ready), .d_rvalid(t3_d_rvalid), .d_rdata(t3_d_rdata),
        .mem_addr(t3_mem_addr), .mem_we(t3_mem_we), .mem_wdata(t3_mem_wdata),
        .mem_wdata_oe(t3_mem_wdata_oe), .mem_rdata(t3_mem_rdata),
        .hold(t3_hold), .block_inst(t3_block_inst)
    );

    // ---------------- memory models: word i holds IB+i after reset ----------------
    logic [31:0] mem1 [256];
    logic [31:0] rd1;
    logic [31:0] mem3 [256];
    logic [31:0] rd3 [3];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem1[i] <= IB + 32'(i);
        end else if (mem_we) begin
            mem1[mem_addr[9:2]] <= mem_wdata;
        end
        rd1 <= mem1[mem_addr[9:2]];
    end
    assign mem_rdata = rd1;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) mem3[i] <= IB + 32'(i);
        end else if (t3_mem_we) begin
            mem3[t3_mem_addr[9:2]] <= t3_mem_wdata;
        end
        rd3[0] <= mem3[t3_mem_addr[9:2]];
        rd3[1] <= rd3[0];
        rd3[2] <= rd3[1];
    end
    assign t3_mem_rdata = rd3[2];

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mkv(
        input logic rst_i, input logic ifq, input logic [29:0] ifa,
        input logic dq, input logic dwe, input logic [31:0] da, input logic [31:0] dwd,
        input logic e_ifr, input logic e_dr, input logic e_hold, input logic [31:0] e_ma,
        input logic e_we, input logic e_oe, input logic [31:0] e_wd,
        input logic e_ifv, input logic [31:0] e_ifd, input logic e_dv, input logic [31:0] e_dd,
        input logic e_blk);
        vec_t v;
        v.rst = rst_i; v.if_req = ifq; v.if_addr = ifa;
        v.d_req = dq; v.d_we = dwe; v.d_addr = da; v.d_wdata = dwd;
        v.e_if_ready = e_ifr; v.e_d_ready = e_dr; v.e_hold = e_hold; v.e_mem_addr = e_ma;
        v.e_mem_we = e_we; v.e_oe = e_oe; v.e_mem_wdata = e_wd;
        v.e_if_rvalid = e_ifv; v.e_if_rdata = e_ifd; v.e_d_rvalid = e_dv; v.e_d_rdata = e_dd;
        v.e_block = e_blk;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive1(input vec_t v);
        rst = v.rst; if_req = v.if_req; if_addr = v.if_addr;
        d_req = v.d_req; d_we = v.d_we; d_addr = v.d_addr; d_wdata = v.d_wdata;
    endtask

    task automatic drive3(input logic ifq, input logic [29:0] ifa, input logic dq, input logic [31:0] da);
        t3_if_req = ifq; t3_if_addr = ifa; t3_d_req = dq; t3_d_we = 1'b0;
        t3_d_addr = da; t3_d_wdata = '0;
    endtask

    vec_t        vecs[$];
    logic [32:0] exp_q[$];

    initial begin
        logic [32:0] e;
        string       pat;
        logic        exp_f;

        if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;
        drive3(1'b0, '0, 1'b0, '0);

        // rst ifq ifa  dq dwe d_addr  d_wdata   | ifr dr hold mem_addr we oe wdata | ifv if_rdata dv d_rdata blk
        vecs.push_back(mkv(1,1,5, 1,0,32'h100,0,          0,0,0,32'h0,  0,0,0,            0,0,        0,0,          1));
        vecs.push_back(mkv(1,0,0, 0,0,0,0,                0,0,0,32'h0,  0,0,0,            0,0,        0,0,          1));
        vecs.push_back(mkv(0,1,0, 0,0,0,0,                1,0,0,32'h0,  0,0,0,            0,0,        0,0,          1));
        vecs.push_back(mkv(0,1,1, 0,0,0,0,                1,0,0,32'h4,  0,0,0,            1,IB,       0,0,          0));
        vecs.push_back(mkv(0,1,2, 0,0,0,0,                1,0,0,32'h8,  0,0,0,            1,IB+1,     0,0,          0));
        vecs.push_back(mkv(0,0,0, 0,0,0,0,                0,0,0,32'h0,  0,0,0,            1,IB+2,     0,0,          0));
        vecs.push_back(mkv(0,1,3, 1,0,32'h100,0,          0,1,1,32'h100,0,0,0,            0,0,        0,0,          1));
        vecs.push_back(mkv(0,1,3, 0,0,0,0,                1,0,0,32'hC,  0,0,0,            0,0,        1,IB+32'h40,  1));
        vecs.push_back(mkv(0,0,0, 0,0,0,0,                0,0,0,32'h0,  0,0,0,            1,IB+3,     0,0,          0));
        vecs.push_back(mkv(0,0,0, 1,1,32'h40,32'hDEADBEEF,0,1,0,32'h40, 1,1,32'hDEADBEEF, 0,0,        0,0,          1));
        vecs.push_back(mkv(0,0,0, 0,0,0,0,                0,0,0,32'h0,  0,0,0,            0,0,        0,0,          1));
        vecs.push_back(mkv(0,0,0, 1,0,32'h40,32'h12345678,0,1,0,32'h40, 0,0,0,            0,0,        0,0,          1));
        vecs.push_back(mkv(0,0,0, 0,0,0,0,                0,0,0,32'h0,  0,0,0,            0,0,        1,32'hDEADBEEF,1));
        vecs.push_back(mkv(0,1,5, 0,0,0,0,                1,0,0,32'h14, 0,0,0,            0,0,        0,0,          1));
        vecs.push_back(mkv(1,1,6, 1,1,32'h80,32'h55,      0,0,0,32'h0,  0,0,0,            0,0,        0,0,          1));
        vecs.push_back(mkv(0,1,7, 0,0,0,0,                1,0,0,32'h1C, 0,0,0,            0,0,        0,0,          1));
        vecs.push_back(mkv(0,0,0, 0,0,0,0,                0,0,0,32'h0,  0,0,0,            1,IB+7,     0,0,          0));
        vecs.push_back(mkv(0,0,0, 0,0,0,0,                0,0,0,32'h0,  0,0,0,            0,0,        0,0,          1));

        foreach (vecs[i]) begin
            @(negedge clk);
            drive1(vecs[i]);
            #1;
            check($sformatf("v%0d if_ready", i),     {31'b0, if_ready},     {31'b0, vecs[i].e_if_ready});
            check($sformatf("v%0d d_ready", i),      {31'b0, d_ready},      {31'b0, vecs[i].e_d_ready});
            check($sformatf("v%0d hold", i),         {31'b0, hold},         {31'b0, vecs[i].e_hold});
            check($sformatf("v%0d mem_addr", i),     mem_addr,              vecs[i].e_mem_addr);
            check($sformatf("v%0d mem_we", i),       {31'b0, mem_we},       {31'b0, vecs[i].e_mem_we});
            check($sformatf("v%0d mem_wdata_oe", i), {31'b0, mem_wdata_oe}, {31'b0, vecs[i].e_oe});
            check($sformatf("v%0d mem_wdata", i),    mem_wdata,             vecs[i].e_mem_wdata);
            check($sformatf("v%0d if_rvalid", i),    {31'b0, if_rvalid},    {31'b0, vecs[i].e_if_rvalid});
            check($sformatf("v%0d if_rdata", i),     if_rdata,              vecs[i].e_if_rdata);
            check($sformatf("v%0d d_rvalid", i),     {31'b0, d_rvalid},     {31'b0, vecs[i].e_d_rvalid});
            check($sformatf("v%0d d_rdata", i),      d_rdata,               vecs[i].e_d_rdata);
            check($sformatf("v%0d block_inst", i),   {31'b0, block_inst},   {31'b0, vecs[i].e_block});
        end

        // Starvation guard: both requesting continuously, streak limit 4.
        pat = "DDDDFDDDDF";
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            rst = 0; if_req = 1; if_addr = 30'd8; d_req = 1; d_we = 0; d_addr = 32'h200; d_wdata = '0;
            #1;
            exp_f = (pat[k] == "F");
            check($sformatf("starve%0d if_ready", k), {31'b0, if_ready}, {31'b0, exp_f});
            check($sformatf("starve%0d d_ready", k),  {31'b0, d_ready},  {31'b0, !exp_f});
            check($sformatf("starve%0d hold", k),     {31'b0, hold},     {31'b0, !exp_f});
        end
        @(negedge clk);
        if_req = 0; d_req = 0;

        // Latency 3: alternating fetch / load grants, responses in grant order.
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            case (k)
                0: drive3(1'b1, 30'd1, 1'b0, 32'h0);
                1: drive3(1'b0, 30'd0, 1'b1, 32'h100);
                2: drive3(1'b1, 30'd2, 1'b0, 32'h0);
                3: drive3(1'b0, 30'd0, 1'b1, 32'h104);
                default: drive3(1'b0, 30'd0, 1'b0, 32'h0);
            endcase
            #1;
            check($sformatf("lat3_%0d if_ready", k), {31'b0, t3_if_ready}, {31'b0, (k == 0 || k == 2)});
            check($sformatf("lat3_%0d d_ready", k),  {31'b0, t3_d_ready},  {31'b0, (k == 1 || k == 3)});
            check($sformatf("lat3_%0d if_rvalid", k), {31'b0, t3_if_rvalid}, {31'b0, (k == 3 || k == 5)});
            check($sformatf("lat3_%0d d_rvalid", k),  {31'b0, t3_d_rvalid},  {31'b0, (k == 4 || k == 6)});
            if (t3_if_rvalid || t3_d_rvalid) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL lat3_%0d response: got unexpected response, expected none queued", k);
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("lat3_%0d resp_src", k), {31'b0, t3_d_rvalid}, {31'b0, e[32]});
                    check($sformatf("lat3_%0d resp_data", k),
                          t3_d_rvalid ? t3_d_rdata : t3_if_rdata, e[31:0]);
                end
            end
            case (k)
                0: exp_q.push_back({1'b0, IB + 32'd1});
                1: exp_q.push_back({1'b1, IB + 32'h40});
                2: exp_q.push_back({1'b0, IB + 32'd2});
                3: exp_q.push_back({1'b1, IB + 32'h41});
                default: ;
            endcase
        end
        check("lat3 exp_q drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
